alu_cmd_stage: RTL and testbench

- Registered command/result wrapper placed directly upstream and downstream of the 8-bit flag ALU (ADD/SUB/AND/OR, flags Z/C/V).
- Accepts tagged ALU commands over a valid/ready interface and drives the ALU operands from a register.
- Captures the ALU result and flags into an output register with valid/ready backpressure.
- Keeps a sticky-overflow flag and a completed-command counter for the sequencer above it.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_pipe_reg.sv | 50 +++++
 rtl/alu_cmd_stage.sv | 116 +++++++++++
 tb/tb_alu_cmd_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command/result stage: operand width, op codes,
// and the packed command and result records carried by the pipeline.
package alu_pkg;

  localparam int ALU_W     = 8;
  // Tag width of the command/result records; the stage's TAG_W must match.
  localparam int CMD_TAG_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0]     a;
    logic [ALU_W-1:0]     b;
    alu_op_e              op;
    logic [CMD_TAG_W-1:0] tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_W-1:0]     r;
    logic                 z;
    logic                 c;
    logic                 v;
    logic [CMD_TAG_W-1:0] tag;
  } alu_res_t;

  // Bundle the ALU outputs with the tag of the command that produced them.
  function automatic alu_res_t make_res(input logic [ALU_W-1:0] r,
                                        input logic z, input logic c, input logic v,
                                        input logic [CMD_TAG_W-1:0] tag);
    alu_res_t res;
    res.r   = r;
    res.z   = z;
    res.c   = c;
    res.v   = v;
    res.tag = tag;
    return res;
  endfunction

endpackage

// File: rtl/alu_pipe_reg.sv
// Generic valid/ready register slice: one entry, full throughput when the
// downstream side is ready, contents held stable while stalled.
module alu_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;
  logic         load_s;

  // Next-state: load when accepting, drain when the consumer takes the entry.
  always_comb begin
    in_ready = ~valid_q | out_ready;
    load_s   = in_valid & in_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice state registers; reset empties the slice and zeroes its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_cmd_stage.sv
// Registered command/result wrapper around the 8-bit flag ALU. S1 holds the
// command and drives the ALU; S2 captures result+flags for the consumer.
// Also tracks a sticky overflow flag and a completed-command counter.
module alu_cmd_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = CMD_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [7:0]       alu_r,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_r,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic [TAG_W-1:0] out_tag,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] cmd_count
);

  alu_cmd_t         s1_in_s, s1_q_s;
  alu_res_t         s2_in_s, s2_q_s;
  logic             s1_valid_s, s2_ready_s, s2_valid_s, xfer_s;
  logic             sticky_d, sticky_q;
  logic [CNT_W-1:0] count_d, count_q;

  // Pack the incoming command and the ALU's answer into their stage records.
  always_comb begin
    s1_in_s.a   = in_a;
    s1_in_s.b   = in_b;
    s1_in_s.op  = alu_op_e'(in_op);
    s1_in_s.tag = CMD_TAG_W'(in_tag);
    s2_in_s     = make_res(alu_r, alu_z, alu_c, alu_v, s1_q_s.tag);
  end

  alu_pipe_reg #(.W($bits(alu_cmd_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_q_s)
  );

  alu_pipe_reg #(.W($bits(alu_res_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (s2_valid_s),
    .out_ready (out_ready),
    .out_data  (s2_q_s)
  );

  // Sticky overflow (a V=1 transfer beats a same-cycle clear) and wrap counter.
  always_comb begin
    xfer_s   = s2_valid_s & out_ready;
    sticky_d = sticky_q;
    count_d  = count_q;
    if (xfer_s & s2_q_s.v) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
    if (xfer_s) begin
      count_d = count_q + CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Status registers for the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign alu_a     = s1_q_s.a;
  assign alu_b     = s1_q_s.b;
  assign alu_op    = s1_q_s.op;
  assign out_valid = s2_valid_s;
  assign out_r     = s2_q_s.r;
  assign out_z     = s2_q_s.z;
  assign out_c     = s2_q_s.c;
  assign out_v     = s2_q_s.v;
  assign out_tag   = TAG_W'(s2_q_s.tag);
  assign sticky_v  = sticky_q;
  assign cmd_count = count_q;

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Scoreboard bench for alu_cmd_stage: stimulus pushes expected results from a
// behavioural reference, a monitor pops and compares on every output transfer.
module tb_alu_cmd_stage;

  typedef struct {
    logic [7:0] r;
    logic       z, c, v;
    logic [3:0] tag;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic [7:0]  alu_a, alu_b, alu_r;
  logic [1:0]  alu_op;
  logic        alu_z, alu_c, alu_v;
  logic        out_valid, out_ready;
  logic [7:0]  out_r;
  logic        out_z, out_c, out_v;
  logic [3:0]  out_tag;
  logic        sticky_v, clr_sticky;
  logic [15:0] cmd_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int          inflight;
  logic        exp_sticky;
  logic [15:0] exp_count;

  alu_cmd_stage #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_z(out_z), .out_c(out_c), .out_v(out_v), .out_tag(out_tag),
    .sticky_v(sticky_v), .clr_sticky(clr_sticky), .cmd_count(cmd_count)
  );

  // Environment ALU driven from the stage's operand register.
  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_r = 8'h00;
    case (alu_op)
      2'b00: begin
        {alu_c, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      2'b01: begin
        {alu_c, alu_r} = {1'b0, alu_a} - {1'b0, alu_b};
        alu_v = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      2'b10: alu_r = alu_a & alu_b;
      default: alu_r = alu_a | alu_b;
    endcase
    alu_z = (alu_r == 8'h00);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t ref_model(input int a, input int b, input int op, input int tag);
    exp_t e;
    int sa, sb, full, sres;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      0: begin
        full = a + b; sres = sa + sb;
        e.r = 8'(full % 256); e.c = (full > 255); e.v = (sres > 127) || (sres < -128);
      end
      1: begin
        full = a - b; sres = sa - sb;
        e.r = 8'((full + 256) % 256); e.c = (a < b); e.v = (sres > 127) || (sres < -128);
      end
      2: e.r = 8'(a & b);
      default: e.r = 8'(a | b);
    endcase
    e.z = (e.r == 8'h00);
    e.tag = 4'(tag);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: inputs already driven; record acceptance.
  task automatic drive_cycle(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(ref_model(in_a, in_b, in_op, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic [3:0] tag);
    bit acc;
    int n;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      drive_cycle(acc);
      n++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout tag=%0d never accepted", tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corner [5];
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF; corner[4] = 8'h01;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  // Monitor: scoreboard pop, status model, handshake and stability checks.
  initial begin : monitor
    exp_t        e;
    bit          xfer, vbit, hold;
    logic [14:0] held;
    hold = 1'b0;
    held = '0;
    inflight = 0;
    exp_sticky = 1'b0;
    exp_count = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        inflight = 0;
        exp_sticky = 1'b0;
        exp_count = 16'h0000;
        hold = 1'b0;
      end else begin
        check("in_ready", in_ready, (inflight < 2) || out_ready);
        check("sticky_v", sticky_v, exp_sticky);
        check("cmd_count", cmd_count, exp_count);
        if (inflight == 0) check("idle_out_valid", out_valid, 1'b0);
        if (hold) check("stall_stable", {out_valid, out_r, out_z, out_c, out_v, out_tag}, {1'b1, held});
        xfer = out_valid && out_ready;
        vbit = 1'b0;
        if (xfer) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual_tag=%0d expected=none", out_tag);
          end else begin
            e = exp_q.pop_front();
            check("out_tag", out_tag, e.tag);
            check("out_r", out_r, e.r);
            check("out_flags", {out_z, out_c, out_v}, {e.z, e.c, e.v});
            vbit = e.v;
          end
          exp_count = exp_count + 16'h0001;
        end
        if (xfer && vbit) exp_sticky = 1'b1;
        else if (clr_sticky) exp_sticky = 1'b0;
        hold = out_valid && !out_ready;
        held = {out_r, out_z, out_c, out_v, out_tag};
        if (in_valid && in_ready) inflight++;
        if (xfer) inflight--;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit          acc;
    logic [15:0] cnt0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 2'b00; in_tag = 4'h0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sticky", sticky_v, 1'b0);
    check("rst_count", cmd_count, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_regs", {alu_a, alu_b, alu_op, out_r, out_z, out_c, out_v, out_tag}, 35'h0);
    @(posedge clk); #1;

    // ADD overflow: result two edges after acceptance, sticky and count follow.
    out_ready = 1'b1;
    send(8'h7F, 8'h01, 2'b00, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    check("add_sticky", sticky_v, 1'b1);
    check("add_count", cmd_count, 16'h0001);

    // SUB borrow then AND zero, in order.
    send(8'h00, 8'h01, 2'b01, 4'd4);
    send(8'hF0, 8'h0F, 2'b10, 4'd5);
    drain();

    // Backpressure: two accepted, third blocked, then released in order.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 2'b00, 4'd10);
    send(8'h80, 8'h80, 2'b00, 4'd11);
    in_a = 8'h55; in_b = 8'hAA; in_op = 2'b11; in_tag = 4'd12; in_valid = 1'b1;
    drive_cycle(acc);
    check("bp_third_blocked", acc, 1'b0);
    repeat (3) drive_cycle(acc);
    check("bp_still_blocked", acc, 1'b0);
    out_ready = 1'b1;
    drive_cycle(acc);
    check("bp_third_accepted", acc, 1'b1);
    in_valid = 1'b0;
    drain();

    // Streaming: ten back-to-back commands.
    cnt0 = cmd_count;
    for (int i = 0; i < 10; i++) send(pick_operand(), pick_operand(), 2'($urandom), 4'(i));
    repeat (2) @(posedge clk);
    #1;
    check("stream_count", cmd_count, cnt0 + 16'd10);
    check("stream_empty", exp_q.size(), 0);

    // Sticky: clear alone, clear with V transfer (set wins), clear alone.
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    check("sticky_cleared", sticky_v, 1'b0);
    send(8'h80, 8'hFF, 2'b00, 4'd6);
    @(posedge clk); #1;
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    check("sticky_set_wins", sticky_v, 1'b1);
    clr_sticky = 1'b1; @(posedge clk); #1; clr_sticky = 1'b0;
    check("sticky_clr", sticky_v, 1'b0);

    // Randomized traffic with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = pick_operand(); in_b = pick_operand();
      in_op = 2'($urandom); in_tag = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      drive_cycle(acc);
    end
    in_valid = 1'b0; clr_sticky = 1'b0;
    drain();

    // Reset with both stages full discards everything.
    send(8'h7F, 8'h7F, 2'b00, 4'd1);
    drain();
    out_ready = 1'b0;
    send(8'h01, 8'h02, 2'b00, 4'd7);
    send(8'h03, 8'h04, 2'b00, 4'd8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_count", cmd_count, 16'h0000);
    check("mid_rst_sticky", sticky_v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", out_valid, 1'b0);
    check("post_rst_count", cmd_count, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
